// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding and default sizing for the boot loader
package imem_boot_loader_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DEPTH_DEF      = 256;
  localparam int RESET_HOLD_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/boot_checksum.sv
// rtl/boot_checksum.sv - 32-bit wrap-around accumulator with clear and add-enable
module boot_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add_en,
  input  logic [31:0] add_data,
  output logic [31:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams words into instruction memory and sequences core reset
// Optional checksum verification is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RESET_HOLD = RESET_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       expected_sum,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              im_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      HOLD_LAST = 4'(RESET_HOLD - 1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] ptr;
  logic [3:0]        hold_cnt;
  logic [ADDR_W:0]   clamped;
  logic              load_req;
  logic              xfer;
  logic              last_xfer;
  logic              sum_ok;

  assign clamped   = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign load_req  = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
  assign xfer      = s_valid && s_ready;
  assign last_xfer = xfer && (remaining == (ADDR_W+1)'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic [31:0] exp_sum_q;

  boot_checksum u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear    (load_req),
    .add_en   (xfer),
    .add_data (s_data),
    .sum      (sum)
  );

  // The final word is still in flight on the bus, so fold it in before comparing.
  assign sum_ok = ((sum + s_data) == exp_sum_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_sum_q <= '0;
      error     <= 1'b0;
    end else begin
      if (load_req) exp_sum_q <= expected_sum;
      error <= (state_nx == ST_ERR);
    end
  end
`else
  logic unused_sum;
  assign unused_sum = ^expected_sum;
  assign sum_ok     = 1'b1;
  assign error      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) state_nx = (clamped == '0) ? ST_HOLD : ST_LOAD;
      end
      ST_LOAD: begin
        if (last_xfer) state_nx = sum_ok ? ST_HOLD : ST_ERR;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = ST_RUN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      s_ready   <= 1'b0;
      im_en     <= 1'b0;
      im_addr   <= '0;
      im_data   <= '0;
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nx;
      s_ready  <= (state_nx == ST_LOAD);
      core_rst <= (state_nx != ST_RUN);
      busy     <= (state_nx == ST_LOAD) || (state_nx == ST_HOLD);
      done     <= (state_nx == ST_RUN);
      im_en    <= xfer;
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 4'd1 : 4'd0;
      if (xfer) begin
        im_addr   <= ptr;
        im_data   <= s_data;
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (load_req) begin
        remaining <= clamped;
        ptr       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed vector bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam logic [31:0] W0 = 32'h00500093;
  localparam logic [31:0] W1 = 32'h00A00113;
  localparam logic [31:0] W2 = 32'h002081B3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [31:0]       expected_sum = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_data = '0;
  logic              im_en;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_data;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  imem_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .word_count   (word_count),
    .expected_sum (expected_sum),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .im_en        (im_en),
    .im_addr      (im_addr),
    .im_data      (im_data),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [8:0]  wc;
    logic        valid;
    logic [31:0] data;
    logic        en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic        crst;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(input logic st, input logic [8:0] wc, input logic v,
                              input logic [31:0] d, input logic en, input logic [7:0] a,
                              input logic [31:0] wd, input logic rdy, input logic cr,
                              input logic bs, input logic dn);
    vec_t r;
    r.start = st; r.wc = wc; r.valid = v; r.data = d;
    r.en = en; r.addr = a; r.wdata = wd; r.ready = rdy; r.crst = cr; r.busy = bs; r.done = dn;
    return r;
  endfunction

  function automatic logic [63:0] pack(input logic en, input logic [7:0] a, input logic [31:0] d,
                                       input logic rdy, input logic cr, input logic bs,
                                       input logic dn, input logic er);
    return {18'd0, en, a, d, rdy, cr, bs, dn, er};
  endfunction

  function automatic logic [31:0] sum_of(input logic [31:0] base, input int n);
    logic [31:0] s = '0;
    int m = (n > 256) ? 256 : n;
    for (int i = 0; i < m; i++) s = s + base + 32'(i);
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Host model: presents word base+k, advances k on each handshake, and checks that every
  // write matches a handshake from the previous cycle at the next contiguous address.
  task automatic run_load(input int wc, input bit stall, input logic [31:0] base,
                          input logic [31:0] esum, input int max_cyc,
                          output int nwr, output int done_cyc, output int err_cyc,
                          output int bad, output logic crst_after);
    int k = 0;
    logic xf;
    nwr = 0; done_cyc = -1; err_cyc = -1; bad = 0; crst_after = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      start        = (c == 0);
      word_count   = 9'(wc);
      expected_sum = esum;
      s_valid      = stall ? (c % 2 == 1) : 1'b1;
      s_data       = base + 32'(k);
      xf           = s_valid && s_ready;
      step();
      start = 1'b0;
      if (c == 0) crst_after = core_rst;
      if (im_en !== xf) bad++;
      if (im_en === 1'b1) begin
        if (im_addr !== 8'(nwr) || im_data !== base + 32'(nwr)) bad++;
        nwr++;
      end
      if (xf) k++;
      if (done === 1'b1) begin done_cyc = c + 1; break; end
      if (error === 1'b1) begin err_cyc = c + 1; break; end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, dc, ec, bad, cnt;
    logic cra;

    tbl[0] = mk(1'b1, 9'd3, 1'b1, W0,           1'b0, 8'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[1] = mk(1'b0, 9'd3, 1'b1, W0,           1'b1, 8'd0, W0,    1'b1, 1'b1, 1'b1, 1'b0);
    tbl[2] = mk(1'b1, 9'd7, 1'b1, W1,           1'b1, 8'd1, W1,    1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 9'd3, 1'b1, W2,           1'b1, 8'd2, W2,    1'b0, 1'b1, 1'b1, 1'b0);
    tbl[4] = mk(1'b0, 9'd3, 1'b0, 32'd0,        1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[5] = mk(1'b1, 9'd3, 1'b0, 32'd0,        1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[6] = mk(1'b0, 9'd3, 1'b0, 32'd0,        1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[7] = mk(1'b0, 9'd3, 1'b0, 32'd0,        1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[8] = mk(1'b0, 9'd3, 1'b1, 32'hFFFFFFFF, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    step();
    step();
    check("reset_outputs", pack(im_en, im_addr, im_data, s_ready, core_rst, busy, done, error),
          pack(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    step();

    expected_sum = sum_of(W0, 0) + W0 + W1 + W2;
    for (int i = 0; i < 9; i++) begin
      start      = tbl[i].start;
      word_count = tbl[i].wc;
      s_valid    = tbl[i].valid;
      s_data     = tbl[i].data;
      step();
      check($sformatf("table_row%0d", i),
            pack(im_en, tbl[i].en ? im_addr : 8'd0, tbl[i].en ? im_data : 32'd0,
                 s_ready, core_rst, busy, done, error),
            pack(tbl[i].en, tbl[i].addr, tbl[i].wdata, tbl[i].ready, tbl[i].crst,
                 tbl[i].busy, tbl[i].done, 1'b0));
    end
    start = 1'b0;
    s_valid = 1'b0;

    run_load(3, 1'b0, 32'hA0000000, sum_of(32'hA0000000, 3), 50, nwr, dc, ec, bad, cra);
    check("rerun_core_rst_rises", 64'(cra), 64'd1);
    check("rerun_writes", 64'(nwr), 64'd3);
    check("rerun_done_cycle", 64'(dc), 64'd8);
    check("rerun_write_order", 64'(bad), 64'd0);

    run_load(3, 1'b1, 32'h00000200, sum_of(32'h200, 3), 50, nwr, dc, ec, bad, cra);
    check("stall_writes", 64'(nwr), 64'd3);
    check("stall_done_cycle", 64'(dc), 64'd10);
    check("stall_no_write_in_gap", 64'(bad), 64'd0);

    run_load(0, 1'b0, 32'h00000300, 32'd0, 50, nwr, dc, ec, bad, cra);
    check("zero_writes", 64'(nwr), 64'd0);
    check("zero_done_cycle", 64'(dc), 64'd5);
    check("zero_no_write", 64'(bad), 64'd0);

    run_load(300, 1'b0, 32'h00010000, sum_of(32'h10000, 300), 400, nwr, dc, ec, bad, cra);
    check("clamp_writes", 64'(nwr), 64'd256);
    check("clamp_done_cycle", 64'(dc), 64'd261);
    check("clamp_addr_data", 64'(bad), 64'd0);

    start = 1'b1; word_count = 9'd5; expected_sum = sum_of(32'h400, 5);
    s_valid = 1'b1; s_data = 32'h400;
    step();
    start = 1'b0;
    step();
    s_data = 32'h401;
    step();
    check("abort_pre_write", pack(im_en, im_addr, im_data, s_ready, core_rst, busy, done, error),
          pack(1'b1, 8'd1, 32'h401, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    check("abort_async_reset", pack(im_en, im_addr, im_data, s_ready, core_rst, busy, done, error),
          pack(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      s_data = 32'h402 + 32'(i);
      step();
      if (im_en !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || core_rst !== 1'b1)
        cnt++;
    end
    check("abort_stays_idle", 64'(cnt), 64'd0);
    s_valid = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(3, 1'b0, 32'd1, 32'd6, 50, nwr, dc, ec, bad, cra);
    check("csum_match_done", 64'(dc), 64'd8);
    run_load(3, 1'b0, 32'd1, 32'd7, 50, nwr, dc, ec, bad, cra);
    check("csum_mismatch_err_cycle", 64'(ec), 64'd4);
    step();
    step();
    check("csum_err_holds", {62'd0, core_rst, error}, 64'd3);
    run_load(3, 1'b0, 32'd1, 32'd6, 50, nwr, dc, ec, bad, cra);
    check("csum_recover_done", 64'(dc), 64'd8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
